// File: rtl/modn_up_counter.sv
// Modulo-MODULUS up counter with enable, clamped parallel load, terminal count and saturating wrap count.
// Latency: q/carry/wraps registered, one cycle after the qualifying edge; tc is combinational.
// Backpressure: none; en acts as a per-cycle advance strobe, and stage k's tc cascades into stage k+1's en.
module modn_up_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int WRAP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              carry,
    output logic [WRAP_W-1:0] wraps
);

    generate
        if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("modn_up_counter: MODULUS out of range for WIDTH");
        end
    endgenerate

    // Top count value; also the clamp ceiling for loads. Fits WIDTH even when MODULUS == 2**WIDTH.
    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

    logic at_max;

    assign at_max = (q == QMAX);
    assign tc     = en & ~load & at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            carry <= 1'b0;
            wraps <= '0;
        end else if (load) begin
            q     <= (load_val > QMAX) ? QMAX : load_val;
            carry <= 1'b0;
        end else if (en) begin
            if (at_max) begin
                q     <= '0;
                carry <= 1'b1;
                if (wraps != {WRAP_W{1'b1}})
                    wraps <= wraps + WRAP_W'(1);
            end else begin
                q     <= q + WIDTH'(1);
                carry <= 1'b0;
            end
        end else begin
            carry <= 1'b0;
        end
    end

endmodule
